// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK transmit path: tone defaults, control states
// and the modulo phase wrap used by both the RTL and reference models.
package fsk_pkg;

    localparam int FSK_LUT_DEPTH  = 360;
    localparam int FSK_STEP_SPACE = 2;
    localparam int FSK_STEP_MARK  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        SYMBOL = 1'b1
    } fsk_state_e;

    // Operands are already in range, so a single conditional subtract suffices.
    function automatic int phase_wrap(input int sum, input int depth);
        return (sum >= depth) ? sum - depth : sum;
    endfunction

endpackage

// File: rtl/fsk_phase_acc.sv
// Continuous-phase accumulator: steps a sine ROM address modulo LUT_DEPTH and
// holds the per-symbol step, which is loaded when a new bit is accepted.
module fsk_phase_acc
    import fsk_pkg::*;
#(
    parameter int LUT_DEPTH  = FSK_LUT_DEPTH,
    parameter int PHASE_W    = 9,
    parameter int STEP_SPACE = FSK_STEP_SPACE,
    parameter int STEP_MARK  = FSK_STEP_MARK
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               advance,
    input  logic               load,
    input  logic               load_mark,
    output logic [PHASE_W-1:0] phase_idx
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] step_q, step_d;
    logic [PHASE_W:0]   sum;

    // The advance in the accept cycle still uses the old step; the new step
    // takes effect from the first cycle of the next symbol.
    always_comb begin
        sum     = {1'b0, phase_q} + {1'b0, step_q};
        phase_d = phase_q;
        step_d  = step_q;
        if (en) begin
            if (advance) begin
                phase_d = PHASE_W'(phase_wrap(32'(sum), LUT_DEPTH));
            end
            if (load) begin
                step_d = load_mark ? PHASE_W'(STEP_MARK) : PHASE_W'(STEP_SPACE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
            step_q  <= PHASE_W'(STEP_SPACE);
        end else begin
            phase_q <= phase_d;
            step_q  <= step_d;
        end
    end

    assign phase_idx = phase_q;

endmodule

// File: rtl/fsk_phase_ctrl.sv
// FSK transmit control: accepts serial bits, holds each for SYMBOL_CYCLES and
// drives a continuous-phase sine ROM address stepping at the mark/space rate.
module fsk_phase_ctrl
    import fsk_pkg::*;
#(
    parameter int LUT_DEPTH     = FSK_LUT_DEPTH,
    parameter int PHASE_W       = 9,
    parameter int SYMBOL_CYCLES = 100,
    parameter int STEP_SPACE    = FSK_STEP_SPACE,
    parameter int STEP_MARK     = FSK_STEP_MARK,
    parameter int CNT_W         = 16
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               en,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic [PHASE_W-1:0] phase_idx,
    output logic               phase_valid,
    output logic               symbol_start,
    output logic               busy
);

    fsk_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             last_cyc;
    logic             accept;

    assign last_cyc  = (cnt_q == CNT_W'(SYMBOL_CYCLES - 1));
    assign bit_ready = en && ((state_q == IDLE) || ((state_q == SYMBOL) && last_cyc));
    assign accept    = bit_valid && bit_ready;

    // A new bit accepted on the last symbol cycle restarts the count directly,
    // so back-to-back symbols have no idle gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        if (en) begin
            start_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = SYMBOL;
                        cnt_d   = '0;
                        start_d = 1'b1;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
                SYMBOL: begin
                    if (last_cyc) begin
                        cnt_d = '0;
                        if (accept) begin
                            start_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    fsk_phase_acc #(
        .LUT_DEPTH (LUT_DEPTH),
        .PHASE_W   (PHASE_W),
        .STEP_SPACE(STEP_SPACE),
        .STEP_MARK (STEP_MARK)
    ) u_acc (
        .clk      (Clk),
        .reset    (reset),
        .en       (en),
        .advance  (state_q == SYMBOL),
        .load     (accept),
        .load_mark(bit_in),
        .phase_idx(phase_idx)
    );

    // A pending start pulse is held in start_q while en is low and shows once en returns.
    assign symbol_start = start_q && en;
    assign phase_valid  = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_fsk_phase_ctrl.sv
// Bench for fsk_phase_ctrl: directed scenarios plus a randomized run, all
// checked against a symbol-level behavioural model of the transmit control.
module tb_fsk_phase_ctrl;
    import fsk_pkg::*;

    localparam int LUT = 360;
    localparam int SC  = 100;
    localparam int SP  = 2;
    localparam int MK  = 4;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready, phase_valid, symbol_start, busy;
    logic [8:0] phase_idx;
    logic       bit_ready7, phase_valid7, symbol_start7, busy7;
    logic [8:0] phase7;

    fsk_phase_ctrl dut (
        .Clk(Clk), .reset(reset), .en(en), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .phase_idx(phase_idx), .phase_valid(phase_valid),
        .symbol_start(symbol_start), .busy(busy)
    );

    fsk_phase_ctrl #(.STEP_MARK(7)) dut7 (
        .Clk(Clk), .reset(reset), .en(en), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready7), .phase_idx(phase7), .phase_valid(phase_valid7),
        .symbol_start(symbol_start7), .busy(busy7)
    );

    always #5 Clk = ~Clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Symbol-level model: a symbol in flight is a position 0..SC-1, phase is an
    // integer advanced modulo LUT while a symbol is in flight.
    int m_busy = 0, m_pos = 0, m_phase = 0, m_step = SP, m_start = 0, m_rst = 0;

    always @(posedge Clk) begin
        int acc;
        m_rst = reset;
        if (reset) begin
            m_busy = 0; m_pos = 0; m_phase = 0; m_step = SP; m_start = 0;
        end else if (en) begin
            acc = (bit_valid && (!m_busy || m_pos == SC - 1)) ? 1 : 0;
            if (m_busy) m_phase = (m_phase + m_step) % LUT;
            if (acc) m_step = bit_in ? MK : SP;
            m_start = acc;
            if (acc) begin
                m_busy = 1; m_pos = 0;
            end else if (m_busy) begin
                if (m_pos == SC - 1) m_busy = 0;
                else m_pos++;
            end
        end
    end

    int prev7 = 0;

    always @(negedge Clk) begin
        chk("bit_ready", bit_ready, (en && (!m_busy || m_pos == SC - 1)) ? 1 : 0);
        chk("phase_idx", phase_idx, m_phase);
        chk("phase_valid", phase_valid, m_busy);
        chk("busy", busy, m_busy);
        chk("symbol_start", symbol_start, (m_start && en) ? 1 : 0);
        chk("phase7_range", (phase7 < 9'(LUT)) ? 1 : 0, 1);
        if (m_rst) chk("phase7_reset", phase7, 0);
        else if (phase7 !== 9'(prev7))
            chk("phase7_step", ((phase7 == (prev7 + 2) % LUT) || (phase7 == (prev7 + 7) % LUT)) ? 1 : 0, 1);
        prev7 = int'(phase7);
    end

    task automatic cyc(input logic r, input logic e, input logic bv, input logic b);
        @(posedge Clk);
        #1;
        reset = r; en = e; bit_valid = bv; bit_in = b;
        @(negedge Clk);
    endtask

    initial begin
        int sent, nst, rel, rdy_busy, act, pf;
        int starts[3];

        chk("wrap_362", phase_wrap(362, LUT), 2);
        chk("wrap_359", phase_wrap(359, LUT), 359);

        // Idle after reset
        repeat (3) cyc(1, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 0, 0);
            chk("idle_ready", bit_ready, 1);
            chk("idle_valid", phase_valid, 0);
            chk("idle_phase", phase_idx, 0);
        end

        // Single space bit
        cyc(0, 1, 1, 0);
        for (int k = 0; k < SC; k++) begin
            cyc(0, 1, 0, 0);
            if (k == 0) chk("space_start", symbol_start, 1);
            chk("space_phase", phase_idx, 2 * k);
        end
        cyc(0, 1, 0, 0);
        chk("space_end_valid", phase_valid, 0);
        chk("space_end_busy", busy, 0);
        chk("space_end_phase", phase_idx, 200);
        cyc(0, 1, 0, 0);
        chk("space_hold_phase", phase_idx, 200);

        // Three mark bits back to back, bit_valid held high
        cyc(1, 1, 0, 0);
        sent = 0; nst = 0; rdy_busy = 0;
        for (int t = 0; t < 400; t++) begin
            logic bv;
            bv = (sent < 3);
            cyc(0, 1, bv, 1);
            if (bv && bit_ready) sent++;
            if (busy && bit_ready) rdy_busy++;
            if (symbol_start === 1'b1 && nst < 3) begin
                starts[nst] = t;
                nst++;
            end
            if (nst > 0) begin
                rel = t - starts[0];
                if (rel == 89)  chk("mark_phase_89", phase_idx, 356);
                if (rel == 90)  chk("mark_phase_90", phase_idx, 0);
                if (rel == 205) chk("mark7_phase_205", phase7, 355);
                if (rel == 206) chk("mark7_phase_206", phase7, 2);
            end
        end
        chk("mark_starts", nst, 3);
        chk("mark_gap_1", starts[1] - starts[0], SC);
        chk("mark_gap_2", starts[2] - starts[1], SC);
        chk("mark_ready_pulses", rdy_busy, 3);

        // Enable dropped for 5 cycles mid-symbol
        cyc(1, 1, 0, 0);
        cyc(0, 1, 1, 0);
        act = 0; pf = 0;
        for (int i = 0; i < 150; i++) begin
            logic e;
            e = !(i >= 30 && i < 35);
            cyc(0, e, 0, 0);
            if (phase_valid && e) act++;
            if (i == 30) pf = int'(phase_idx);
            if (i >= 31 && i <= 35) chk("freeze_phase", phase_idx, pf);
            if (i >= 30 && i < 35) chk("freeze_ready", bit_ready, 0);
        end
        chk("freeze_value", pf, 60);
        chk("freeze_active_cycles", act, SC);

        // Reset at cnt=40 of a mark symbol, with a bit offered in the same cycle
        cyc(1, 1, 0, 0);
        cyc(0, 1, 1, 1);
        for (int i = 0; i <= 40; i++) cyc(0, 1, 0, 0);
        chk("abort_pre_busy", busy, 1);
        chk("abort_pre_phase", phase_idx, 160);
        cyc(1, 1, 1, 1);
        cyc(0, 1, 0, 0);
        chk("abort_phase", phase_idx, 0);
        chk("abort_valid", phase_valid, 0);
        chk("abort_busy", busy, 0);
        cyc(0, 1, 0, 0);
        chk("abort_discard_busy", busy, 0);
        chk("abort_discard_start", symbol_start, 0);

        // Randomized traffic
        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
